// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types: icache address split and frame layout
package cpu_types_pkg;

    localparam int ISETS = 16;

    typedef struct packed {
        logic [25:0] tag;
        logic [3:0]  idx;
        logic [1:0]  bytoff;
    } icachef_t;

    // Tag field is sized for the widest tag any SETS value can produce; narrower tags are zero-extended.
    typedef struct packed {
        logic        valid;
        logic [29:0] tag;
        logic [31:0] data;
    } icache_frame_t;

endpackage

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped read-only instruction cache, one word per frame, single outstanding miss
module icache
    import cpu_types_pkg::*;
#(
    parameter int SETS = ISETS
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
);

    localparam int IBITS = $clog2(SETS);

    typedef enum logic {IDLE, FETCH} icache_state_t;

    icache_state_t r_state;
    icache_state_t w_next_state;
    icache_frame_t r_frames [SETS];
    logic [31:0]   r_miss_addr;

    icache_frame_t    w_frame;
    logic [IBITS-1:0] w_idx;
    logic [IBITS-1:0] w_miss_idx;
    logic [29:0]      w_req_tag;
    logic [29:0]      w_miss_tag;
    logic             w_match;
    logic             w_latch;
    logic             w_fill;
    logic             w_unused;

    assign w_unused   = &{1'b0, imemaddr[1:0]};
    assign w_idx      = imemaddr[IBITS+1:2];
    assign w_req_tag  = 30'(imemaddr[31:IBITS+2]);
    assign w_miss_idx = r_miss_addr[IBITS+1:2];
    assign w_miss_tag = 30'(r_miss_addr[31:IBITS+2]);
    assign w_frame    = r_frames[w_idx];
    assign w_match    = w_frame.valid && (w_frame.tag == w_req_tag);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= IDLE;
            r_miss_addr <= '0;
            for (int i = 0; i < SETS; i++) begin
                r_frames[i] <= '0;
            end
        end else begin
            r_state <= w_next_state;
            if (w_latch) begin
                r_miss_addr <= {imemaddr[31:2], 2'b00};
            end
            // The fill always lands at the latched miss address, whatever the datapath is asking for now.
            if (w_fill) begin
                r_frames[w_miss_idx] <= '{valid: 1'b1, tag: w_miss_tag, data: iload};
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        ihit         = 1'b0;
        iREN         = 1'b0;
        iaddr        = '0;
        w_latch      = 1'b0;
        w_fill       = 1'b0;
        imemload     = w_frame.data;
        case (r_state)
            IDLE: begin
                ihit = imemREN & w_match;
                if (imemREN && !w_match) begin
                    w_latch      = 1'b1;
                    w_next_state = FETCH;
                end
            end
            FETCH: begin
                iREN  = 1'b1;
                iaddr = r_miss_addr;
                if (!iwait) begin
                    w_fill       = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - randomized self-checking bench for icache against a per-index word-address model
module tb_icache;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    int vectors = 0;
    int errors  = 0;

    bit          ref_valid [16];
    logic [29:0] ref_word  [16];
    logic [31:0] mem [logic [31:0]];

    icache #(.SETS(16)) dut (
        .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
        .iwait(iwait), .iload(iload)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] wa);
        if (mem.exists(wa)) return mem[wa];
        return {wa[17:2], ~wa[17:2]} ^ 32'h1357_9BDF;
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        icachef_t f;
        f = a;
        return ref_valid[f.idx] && (ref_word[f.idx] == a[31:2]);
    endfunction

    function automatic void model_fill(input logic [31:0] a);
        icachef_t f;
        f = a;
        ref_valid[f.idx] = 1'b1;
        ref_word[f.idx]  = a[31:2];
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;
    endfunction

    // mode 0: plain request, 1: redirect to ra during the fill, 2: drop imemREN during the fill
    task automatic access(input logic [31:0] a, input int waits, input int mode, input logic [31:0] ra);
        logic [31:0] wa;
        bit          exp_hit;
        bit          exp_after;
        wa       = {a[31:2], 2'b00};
        exp_hit  = model_hit(a);
        imemREN  = 1'b1;
        imemaddr = a;
        iwait    = 1'b1;
        #1;
        vectors++;
        if (ihit !== exp_hit) begin
            errors++;
            $display("FAIL req_hit addr=%h got %b want %b", a, ihit, exp_hit);
        end
        vectors++;
        if (iREN !== 1'b0) begin
            errors++;
            $display("FAIL idle_iren addr=%h got %b want 0", a, iREN);
        end
        if (exp_hit) begin
            vectors++;
            if (imemload !== mem_word(wa)) begin
                errors++;
                $display("FAIL hit_data addr=%h got %h want %h", a, imemload, mem_word(wa));
            end
        end else begin
            @(posedge CLK); #1;
            for (int c = 0; c <= waits; c++) begin
                if (mode == 1) imemaddr = ra;
                if (mode == 2) imemREN = 1'b0;
                iwait = (c < waits);
                iload = (c < waits) ? $urandom : mem_word(wa);
                #1;
                vectors++;
                if (iREN !== 1'b1 || iaddr !== wa || ihit !== 1'b0) begin
                    errors++;
                    $display("FAIL fetch cyc=%0d iREN=%b iaddr=%h ihit=%b want 1 %h 0", c, iREN, iaddr, ihit, wa);
                end
                @(posedge CLK); #1;
            end
            iwait = 1'b1;
            model_fill(wa);
            exp_after = imemREN && model_hit(imemaddr);
            vectors++;
            if (iREN !== 1'b0 || ihit !== exp_after) begin
                errors++;
                $display("FAIL post_fill addr=%h iREN=%b ihit=%b want 0 %b", a, iREN, ihit, exp_after);
            end
            if (exp_after) begin
                vectors++;
                if (imemload !== mem_word({imemaddr[31:2], 2'b00})) begin
                    errors++;
                    $display("FAIL fill_data addr=%h got %h want %h", imemaddr, imemload, mem_word({imemaddr[31:2], 2'b00}));
                end
            end
        end
        imemREN = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0; imemREN = 1'b1; imemaddr = 32'h0; iwait = 1'b1; iload = '0;
        model_clear();
        repeat (2) @(posedge CLK);
        #1;
        vectors++;
        if (ihit !== 1'b0 || iREN !== 1'b0 || iaddr !== 32'h0 || imemload !== 32'h0) begin
            errors++;
            $display("FAIL reset ihit=%b iREN=%b iaddr=%h imemload=%h want 0 0 0 0", ihit, iREN, iaddr, imemload);
        end
        nRST = 1'b1; imemREN = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_directed();
        mem[32'h40]  = 32'h8C22_0004;
        mem[32'h80]  = 32'h1234_5678;
        mem[32'h300] = 32'hDEAD_BEEF;
        access(32'h40, 2, 0, 0);
        access(32'h40, 0, 0, 0);
        access(32'h42, 0, 0, 0);
        access(32'h80, 1, 0, 0);
        access(32'h40, 0, 0, 0);
        access(32'h100, 2, 1, 32'h200);
        access(32'h200, 0, 0, 0);
        access(32'h300, 3, 2, 0);
        access(32'h300, 0, 0, 0);
        access(32'hFFFF_FFFC, 1, 0, 0);
        access(32'hFFFF_FFFC, 0, 0, 0);
        access(32'h3C, 0, 0, 0);
        access(32'hFFFF_FFFE, 0, 0, 0);
    endtask

    task automatic test_reset_mid_fetch();
        access(32'h500, 0, 0, 0);
        imemREN = 1'b1; imemaddr = 32'h600; iwait = 1'b1;
        @(posedge CLK); #1;
        vectors++;
        if (iREN !== 1'b1) begin
            errors++;
            $display("FAIL rst_fetch_entry iREN=%b want 1", iREN);
        end
        #2 nRST = 1'b0; imemaddr = 32'h500;
        #1;
        vectors++;
        if (iREN !== 1'b0 || ihit !== 1'b0 || iaddr !== 32'h0) begin
            errors++;
            $display("FAIL rst_async iREN=%b ihit=%b iaddr=%h want 0 0 0", iREN, ihit, iaddr);
        end
        model_clear();
        @(posedge CLK); #1;
        nRST = 1'b1; imemREN = 1'b0;
        @(posedge CLK); #1;
        access(32'h500, 1, 0, 0);
        access(32'h500, 0, 0, 0);
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 15) == 0) a = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
            else a = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            access(a, $urandom_range(0, 3), ($urandom_range(0, 4) == 0) ? 2 : 0, 0);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid_fetch();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
